uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the host at full clock rate into a synchronous FIFO. It then hands them one at a time to the transmitter through its `start` / `data_in` / `busy` handshake, so the host never has to poll `busy` between characters. Its outputs `tx_start` and `tx_data` connect to the transmitter's `start` and `data_in`, and the transmitter's `busy` returns on `tx_busy`.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/uart_tx_fifo.sv | 92 +++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit launch sequencer states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; writes when full and reads when
// empty are ignored, so callers may strobe freely.
module sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            wr_fire;
  logic            rd_fire;

  assign wr_fire = wr_en & ~full_q;
  assign rd_fire = rd_en & ~empty_q;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: queues host bytes and launches them one
// at a time through the transmitter's start/busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic                     idle
);

  tx_state_e         state_q;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign pop = (state_q == StIdle) & ~empty & ~tx_busy;

  // tx_start and tx_data are flops so nothing from the host side reaches the transmitter
  // combinationally; tx_data only changes on a pop, never while the transmitter is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data  <= head_data;
            tx_start <= 1'b1;
            state_q  <= StLaunch;
          end
        end
        StLaunch: begin
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
    end
  end

  assign idle = empty & (state_q == StIdle) & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo with a queue-based reference model and a simple
// transmitter busy model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, overflow, tx_start, idle;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored bytes as a queue, plus the launch phase
  // (0 idle, 1 launching, 2 awaiting busy, 3 awaiting busy release).
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  int         ph = 0;
  logic       exp_start = 1'b0;
  logic       exp_ovf = 1'b0;
  logic [7:0] exp_data = 8'h00;
  int         cyc = 0;
  bit         m_pop, m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      ph        = 0;
      exp_start = 1'b0;
      exp_ovf   = 1'b0;
      exp_data  = 8'h00;
    end else begin
      cyc++;
      m_pop     = (ph == 0) && (mq.size() != 0) && !tx_busy;
      m_full    = (mq.size() == DEPTH);
      exp_ovf   = wr_en && m_full;
      exp_start = m_pop;
      if (m_pop) exp_data = mq.pop_front();
      if (ph == 1) ph = 2;
      else if (ph == 2 && tx_busy) ph = 3;
      else if (ph == 3 && !tx_busy) ph = 0;
      if (m_pop) ph = 1;
      if (wr_en && !m_full) begin
        mq.push_back(wr_data);
        acc.push_back(wr_data);
      end
    end
  end

  // Transmitter stand-in: busy rises one cycle after start and lasts len cycles.
  int unsigned len = 10;
  bit          hold_busy = 1'b0;
  int          busy_rem = 0;
  bit          start_seen = 1'b0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_rem   = 0;
      start_seen = 1'b0;
      tx_busy    = 1'b0;
    end else begin
      #2;
      if (start_seen) begin
        busy_rem   = int'(len);
        start_seen = 1'b0;
      end else if (busy_rem > 0) begin
        busy_rem--;
      end
      if (tx_start) start_seen = 1'b1;
      tx_busy = hold_busy || (busy_rem > 0);
    end
  end

  // Compare process and observation log.
  logic [7:0] launched[$];
  int         n_start = 0;
  int         n_ovf = 0;
  int         max_cnt = 0;
  int         start_cyc = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("tx_start", 32'(tx_start), 32'(exp_start));
      chk("tx_data", 32'(tx_data), 32'(exp_data));
      chk("idle", 32'(idle), 32'(mq.size() == 0 && ph == 0 && !tx_busy));
      if (tx_busy) chk("tx_data_hold", 32'(tx_data), 32'(prev_data));
      prev_data = tx_data;
      if (tx_start) begin
        launched.push_back(tx_data);
        n_start++;
        start_cyc = cyc;
      end
      if (overflow) n_ovf++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  task automatic drive(input logic en, input logic [7:0] d);
    @(negedge clk);
    #1;
    wr_en   = en;
    wr_data = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_empty"}, 32'(empty), 32'(1));
    chk({tag, "_count"}, 32'(count), 32'(0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(0));
    chk({tag, "_tx_start"}, 32'(tx_start), 32'(0));
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    chk({tag, "_idle"}, 32'(idle), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ob[DEPTH];
    int         wr_edge;
    int         n0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // Single write: launch one edge after the write edge.
    len = 10;
    drive(1'b0, 8'h00);
    launched.delete();
    drive(1'b1, 8'h55);
    wr_edge = cyc + 1;
    drive(1'b0, 8'h00);
    for (int i = 0; i < 20 && launched.size() == 0; i++) drive(1'b0, 8'h00);
    chk("single_n", 32'(launched.size()), 32'(1));
    if (launched.size() > 0) chk("single_data", 32'(launched[0]), 32'h55);
    chk("single_latency", 32'(start_cyc - wr_edge), 32'(1));
    for (int i = 0; i < 40 && !idle; i++) drive(1'b0, 8'h00);
    chk("single_idle", 32'(idle), 32'(1));

    // Burst of three.
    launched.delete();
    max_cnt = 0;
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    for (int i = 0; i < 200 && !(launched.size() == 3 && idle); i++) drive(1'b0, 8'h00);
    chk("burst_n", 32'(launched.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      if (i < launched.size()) chk("burst_order", 32'(launched[i]), 32'(i + 1));
    chk("burst_maxcount", 32'(max_cnt), 32'(2));
    chk("burst_count_end", 32'(count), 32'(0));

    // Overflow with the transmitter held busy.
    hold_busy = 1'b1;
    launched.delete();
    n_ovf = 0;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      ob[i] = 8'($urandom);
      drive(1'b1, ob[i]);
    end
    drive(1'b0, 8'h00);
    chk("ovf_full", 32'(full), 32'(1));
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_none_yet", 32'(n_ovf), 32'(0));
    drive(1'b1, 8'hEE);
    drive(1'b1, 8'hEF);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk("ovf_pulses", 32'(n_ovf), 32'(2));
    hold_busy = 1'b0;
    for (int i = 0; i < 600 && !(launched.size() == DEPTH && idle); i++) drive(1'b0, 8'h00);
    chk("ovf_launched", 32'(launched.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < launched.size()) chk("ovf_order", 32'(launched[i]), 32'(ob[i]));

    // Write on the same edge as a pop with one byte stored.
    launched.delete();
    acc.delete();
    hold_busy = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    chk("simul_pre_count", 32'(count), 32'(1));
    hold_busy = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'hC3;
    drive(1'b0, 8'h00);
    chk("simul_count", 32'(count), 32'(1));
    chk("simul_start", 32'(tx_start), 32'(1));
    chk("simul_data", 32'(tx_data), 32'h3C);

    // Random traffic, several times around the pointers.
    for (int i = 0; i < 3 * DEPTH + 8; i++) begin
      len = $urandom_range(1, 5);
      drive(logic'($urandom_range(0, 3) != 0), 8'($urandom));
    end
    drive(1'b0, 8'h00);
    for (int i = 0; i < 3000 && !(idle && launched.size() == acc.size()); i++)
      drive(1'b0, 8'h00);
    chk("rand_n", 32'(launched.size()), 32'(acc.size()));
    for (int i = 0; i < acc.size(); i++)
      if (i < launched.size()) chk("rand_order", 32'(launched[i]), 32'(acc[i]));

    // Reset while awaiting busy release with five bytes queued.
    len = 20;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'hA0 + i));
    drive(1'b0, 8'h00);
    for (int i = 0; i < 100 && !(ph == 3 && mq.size() == 5); i++) drive(1'b0, 8'h00);
    chk("rmf_reached", 32'(ph == 3 && mq.size() == 5), 32'(1));
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("rmf");
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    rst = 1'b0;
    n0 = n_start;
    repeat (30) drive(1'b0, 8'h00);
    chk("rmf_no_start", 32'(n_start - n0), 32'(0));
    chk("rmf_idle", 32'(idle), 32'(1));
    chk("rmf_count", 32'(count), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
